divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//  Sequential restoring divider for MIPS DIV/DIVU, the inverse of the shift-add multiplier.
//  Computes quotient (LO) and remainder (HI) one bit per cycle, in signed or unsigned mode.
//  Sits beside the multiplier in EX. The pipeline stalls while ready is low and writes HI/LO on done.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width; iteration count = WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  start        in   1      request a divide; sampled only while ready=1
//  is_signed    in   1      1=DIV (two's complement), 0=DIVU
//  dividend     in   WIDTH  numerator; sampled with start
//  divisor      in   WIDTH  denominator; sampled with start
//  ready        out  1      1 = idle, can accept start
//  done         out  1      one-cycle pulse: results valid this cycle
//  quotient     out  WIDTH  LO result; held until next accepted start
//  remainder    out  WIDTH  HI result; held until next accepted start
//  div_by_zero  out  1      set with done if divisor==0; held until next accepted start
// BEHAVIOUR
//  Reset (one clk edge, reset=1): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
//    Reset wins over start in the same cycle. Reset mid-operation aborts and discards partial results.
//  States: IDLE -> RUN -> FIX -> IDLE. ready=1 only in IDLE.
//  IDLE: if start, latch the following and go to RUN (or FIX if divisor==0):
//    - abs(dividend) and abs(divisor) (abs only when is_signed and MSB=1; magnitude taken as unsigned WIDTH bits)
//    - sign_q = is_signed & (dividend[MSB]^divisor[MSB]); sign_r = is_signed & dividend[MSB]
//    - count=WIDTH; partial remainder=0; done=0
//  RUN, one step per cycle:
//    - shift {rem,quo} left 1, bringing in the next dividend MSB
//    - trial = rem - abs_divisor (WIDTH+1 bits)
//    - if trial >= 0: rem=trial, quo LSB=1; else quo LSB=0
//    - count-=1; when count reaches 0 go to FIX
//  FIX, one cycle: quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem; -> IDLE, done=1.
//  Latency: start sampled at edge N. ready=0 after edges N+1..N+WIDTH+1.
//    Results, done=1 and ready=1 appear after edge N+WIDTH+2, so 34 cycles for WIDTH=32.
//  Divide by zero: IDLE -> FIX directly, with no iterations. Latency 2 cycles.
//    Results: quotient = all ones, remainder = dividend (raw input, not negated), div_by_zero=1.
//  Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives quotient=0x80000000, remainder=0, no flag.
//  start while ready=0 is ignored; inputs may change freely once accepted.
//  start in the cycle done=1 is accepted, because ready=1 that cycle. done drops the next cycle.
//  done is high for exactly one cycle per accepted operation. It never asserts after reset without a start.
//  Outputs are registered only; no combinational path from inputs to outputs.
// TESTING
//  1) DIVU 100/7: quotient=14, remainder=2, done exactly 34 cycles after start, ready low for 33 cycles.
//  2) DIV -7/2 (0xFFFFFFF9, 0x2): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7/-2: quotient=0xFFFFFFFD, remainder=1.
//  3) DIV 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1: quotient=0xFFFFFFFF, remainder=0.
//  4) DIVU 5/0: done after 2 cycles, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5. Next valid divide clears the flag.
//  5) start 100/7 then reset at cycle 10: next cycle ready=1, all outputs 0, no done. Re-issue 100/7: results as in 1).
//  6) Back-to-back and busy starts:
//     - start pulses mid-run are ignored
//     - start on the done cycle is accepted
//     - random signed/unsigned operands (including 0 dividend and divisor=1) match a reference model

Source files
------------

// File: rtl/divider_if.sv
// Handshake and operand/result bundle shared by the divider and its requester.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, is_signed, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    // Divider side: consumes operands, produces status and results.
    modport slave (
        input  start, is_signed, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider.sv
// Sequential restoring divider for MIPS DIV/DIVU.
// Works on magnitudes one quotient bit per cycle, then applies the result signs
// in a final fix-up cycle. Divide-by-zero skips the iterations entirely.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;       // partial remainder (magnitude)
    logic [WIDTH-1:0] quo_q;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] div_q;       // divisor magnitude
    logic             sign_q_q;    // negate quotient at fix-up
    logic             sign_r_q;    // negate remainder at fix-up
    logic             dz_q;        // current operation has a zero divisor
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH:0]   shifted_s;
    logic             fits_s;
    logic [WIDTH-1:0] trial_s;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // Two's complement negate when requested.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return (~v) + ONE_W;
        end else begin
            return v;
        end
    endfunction

    // Magnitude of an operand: negated only for signed operations with the MSB set.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[WIDTH-1]);
    endfunction

    // One restoring step: shift in the next dividend bit and subtract if the divisor fits.
    always_comb begin
        shifted_s = {rem_q, quo_q[WIDTH-1]};
        fits_s    = (shifted_s >= {1'b0, div_q});
        // When the divisor fits, the true difference is below 2^WIDTH, so the low bits suffice.
        trial_s   = shifted_s[WIDTH-1:0] - div_q;
        if (fits_s) begin
            rem_d = trial_s;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= {CW{1'b0}};
            rem_q         <= ZERO_W;
            quo_q         <= ZERO_W;
            div_q         <= ZERO_W;
            sign_q_q      <= 1'b0;
            sign_r_q      <= 1'b0;
            dz_q          <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            quotient_q    <= ZERO_W;
            remainder_q   <= ZERO_W;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sign_q_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        sign_r_q <= bus.is_signed & bus.dividend[WIDTH-1];
                        rem_q    <= ZERO_W;
                        count_q  <= CNT_INIT;
                        ready_q  <= 1'b0;
                        if (bus.divisor == ZERO_W) begin
                            // Keep the raw dividend; it becomes the remainder unchanged.
                            dz_q    <= 1'b1;
                            quo_q   <= bus.dividend;
                            div_q   <= ZERO_W;
                            state_q <= S_FIX;
                        end else begin
                            dz_q    <= 1'b0;
                            quo_q   <= magnitude(bus.dividend, bus.is_signed);
                            div_q   <= magnitude(bus.divisor, bus.is_signed);
                            state_q <= S_RUN;
                        end
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_FIX: begin
                    if (dz_q) begin
                        quotient_q    <= ONES_W;
                        remainder_q   <= quo_q;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        quotient_q    <= cond_neg(quo_q, sign_q_q);
                        remainder_q   <= cond_neg(rem_q, sign_r_q);
                        div_by_zero_q <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_divider;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // MIPS DIV/DIVU semantics: truncating division, remainder takes the dividend's sign.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b; dz = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; dz = 1'b0;
        end else begin
            q = sa / sb; r = sa % sb; dz = 1'b0;
        end
    endfunction

    // Issue one divide at the current negedge (ready assumed) and check its outcome.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit poke, input bit wait_after, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          cyc;
        int          low;
        int          exp_lat;
        ref_div(a, b, s, eq, er, edz);
        exp_lat = (b == 32'd0) ? 2 : 34;
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
        cyc = 0;
        low = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.dividend  = $urandom;
                bus.divisor   = $urandom;
                bus.is_signed = 1'($urandom_range(0, 1));
            end
            if (poke && (cyc == 5 || cyc == 12)) bus.start = 1'b1;
            else bus.start = 1'b0;
            if (!bus.ready) low++;
        end while (!bus.done && cyc < 60);
        chk({tag, " done"},     32'(bus.done),        32'd1);
        chk({tag, " latency"},  32'(cyc),             32'(exp_lat));
        chk({tag, " busy_len"}, 32'(low),             32'(exp_lat - 1));
        chk({tag, " ready"},    32'(bus.ready),       32'd1);
        chk({tag, " quotient"}, bus.quotient,         eq);
        chk({tag, " remainder"},bus.remainder,        er);
        chk({tag, " dz"},       32'(bus.div_by_zero), 32'(edz));
        if (wait_after) begin
            bus.start = 1'b0;
            @(negedge clk);
            chk({tag, " done_drop"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        int          dones;
        logic [31:0] ra;
        logic [31:0] rb;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(bus.ready), 32'd1);
        chk("rst done",  32'(bus.done),  32'd0);
        chk("rst quo",   bus.quotient,   32'd0);
        chk("rst rem",   bus.remainder,  32'd0);
        chk("rst dz",    32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("idle no done", 32'(dones), 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, "divu_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b1, "div_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, "div_7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, "div_ovf");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, "divu_max_1");
        run_op(32'd5, 32'd0, 1'b0, 1'b0, 1'b1, "divu_5_0");
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, 1'b1, "div_m7_0");

        // Abort a running divide with reset; outputs from the divide-by-zero above must clear.
        bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.is_signed = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort ready", 32'(bus.ready), 32'd1);
        chk("abort done",  32'(bus.done),  32'd0);
        chk("abort quo",   bus.quotient,   32'd0);
        chk("abort rem",   bus.remainder,  32'd0);
        chk("abort dz",    32'(bus.div_by_zero), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, "reissue");

        // Busy starts are ignored; starts on the done cycle chain back to back.
        run_op(32'd1000, 32'd33, 1'b0, 1'b1, 1'b0, "poke_u");
        run_op(32'hFFFF_FC18, 32'd33, 1'b1, 1'b1, 1'b0, "poke_s");
        run_op(32'd0, 32'd1, 1'b1, 1'b0, 1'b0, "zero_by_1");
        run_op(32'd12345, 32'd0, 1'b1, 1'b0, 1'b0, "b2b_dz");
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0, "min_by_1");
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = 32'd0 - 32'($urandom_range(1, 15));
                2:       rb = (k % 8 == 0) ? 32'd0 : 32'd1;
                default: rb = $urandom;
            endcase
            if (k % 6 == 3) ra = 32'd0;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, (k == 23), $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
